memory_mapper: RTL and testbench

Parametrised successor to the fixed two-bank expansion control: splits $8000-$FFFF into NUM_WINDOWS equal windows, each independently mapped to one of 2^PAGE_BITS expansion-RAM pages with its own write-protect. Window settings are written to shadow registers and applied atomically by a commit write. A key-sequence lock guards all configuration writes. Sits between the CPU bus and address decoding and supplies the expansion bank address and read-only flag.

---
 rtl/memory_mapper_pkg.sv | 46 ++++
 rtl/memory_mapper_if.sv | 32 +++
 rtl/memory_mapper_unlock.sv | 80 ++++++++
 rtl/memory_mapper.sv | 170 +++++++++++++++++
 tb/tb_memory_mapper.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_mapper_pkg.sv
// -----------------------------------------------------------------------------
// memory_mapper_pkg
// Shared constants, types and helpers for the windowed expansion-RAM mapper:
// CTRL/WIN register bit positions, register offsets, unlock key bytes, the
// lock FSM state type and address-range helpers for the peek holes.
// -----------------------------------------------------------------------------
package memory_mapper_pkg;

    localparam int CPU_ADDR_WIDTH = 16;
    localparam int DATA_WIDTH     = 8;

    // CTRL register bit indices
    localparam int MEM_MAP_CTRL_ENABLE      = 7;
    localparam int MEM_MAP_CTRL_IO_PEEK     = 6;
    localparam int MEM_MAP_CTRL_SCREEN_PEEK = 5;
    localparam int MEM_MAP_CTRL_COMMIT      = 0;

    // WIN register write-protect bit
    localparam int MEM_MAP_WIN_WP = 7;

    // Register offsets from REG_BASE
    localparam logic [3:0] MEM_MAP_REG_CTRL = 4'd0;
    localparam logic [3:0] MEM_MAP_REG_KEY  = 4'd1;
    localparam logic [3:0] MEM_MAP_REG_WIN0 = 4'd2;

    // Unlock key bytes, written in this order to the KEY register
    localparam logic [7:0] MEM_MAP_KEY1 = 8'hA5;
    localparam logic [7:0] MEM_MAP_KEY2 = 8'h5A;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        UNLOCKED = 2'd2
    } mem_map_lock_t;

    // Screen peek hole: $8000-$8FFF
    function automatic logic mem_map_in_screen_peek(input logic [15:0] addr);
        return (addr[15:12] == 4'h8);
    endfunction

    // I/O peek hole: $E810-$EFFF; $E800-$E80F always stays mapped
    function automatic logic mem_map_in_io_peek(input logic [15:0] addr);
        return (addr[15:11] == 5'b11101) && (addr[15:4] != 12'hE80);
    endfunction

endpackage

// File: rtl/memory_mapper_if.sv
// -----------------------------------------------------------------------------
// memory_mapper_if
// CPU-side bus seen by the mapper.
//   cpu_be        bus enable, qualifies writes and decode
//   cpu_wr_strobe one-cycle write strobe
//   cpu_addr      CPU address
//   cpu_data      CPU write data
// master: CPU / bench side, slave: memory_mapper side.
// -----------------------------------------------------------------------------
interface memory_mapper_if;
    import memory_mapper_pkg::*;

    logic                      cpu_be;
    logic                      cpu_wr_strobe;
    logic [CPU_ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]     cpu_data;

    modport master (
        output cpu_be,
        output cpu_wr_strobe,
        output cpu_addr,
        output cpu_data
    );

    modport slave (
        input cpu_be,
        input cpu_wr_strobe,
        input cpu_addr,
        input cpu_data
    );

endinterface

// File: rtl/memory_mapper_unlock.sv
// -----------------------------------------------------------------------------
// mem_map_unlock
// Key-sequence lock guarding configuration writes.
//   sys_clock_i  clock
//   reset_n_i    synchronous active-low reset
//   reg_wr_i     a register-file write happens this cycle
//   is_key_i     that write targets the KEY register
//   data_i       write data
//   unlocked_o   registered: configuration writes are accepted
// Sequence: $A5 then $5A on KEY. Any other register write between the two
// keys aborts; any KEY write while unlocked relocks ($A5 restarts the
// sequence). With LOCK_EN = 0 the lock is held open.
// -----------------------------------------------------------------------------
module mem_map_unlock
    import memory_mapper_pkg::*;
#(
    parameter bit LOCK_EN = 1'b1
) (
    input  logic       sys_clock_i,
    input  logic       reset_n_i,
    input  logic       reg_wr_i,
    input  logic       is_key_i,
    input  logic [7:0] data_i,
    output logic       unlocked_o
);

    mem_map_lock_t state_r;
    logic          unlocked_r;

    // Lock FSM with registered unlocked flag
    always_ff @(posedge sys_clock_i) begin
        if (!reset_n_i || !LOCK_EN) begin
            state_r    <= LOCK_EN ? LOCKED : UNLOCKED;
            unlocked_r <= !LOCK_EN;
        end else if (reg_wr_i) begin
            case (state_r)
                LOCKED: begin
                    if (is_key_i && (data_i == MEM_MAP_KEY1)) begin
                        state_r    <= KEY1;
                        unlocked_r <= 1'b0;
                    end else begin
                        state_r    <= LOCKED;
                        unlocked_r <= 1'b0;
                    end
                end
                KEY1: begin
                    if (is_key_i && (data_i == MEM_MAP_KEY2)) begin
                        state_r    <= UNLOCKED;
                        unlocked_r <= 1'b1;
                    end else begin
                        state_r    <= LOCKED;
                        unlocked_r <= 1'b0;
                    end
                end
                UNLOCKED: begin
                    if (is_key_i && (data_i == MEM_MAP_KEY1)) begin
                        state_r    <= KEY1;
                        unlocked_r <= 1'b0;
                    end else if (is_key_i) begin
                        state_r    <= LOCKED;
                        unlocked_r <= 1'b0;
                    end else begin
                        state_r    <= UNLOCKED;
                        unlocked_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= LOCKED;
                    unlocked_r <= 1'b0;
                end
            endcase
        end else begin
            state_r    <= state_r;
            unlocked_r <= unlocked_r;
        end
    end

    assign unlocked_o = unlocked_r;

endmodule

// File: rtl/memory_mapper.sv
// -----------------------------------------------------------------------------
// memory_mapper
// Splits $8000-$FFFF into NUM_WINDOWS equal windows, each mapped to one of
// 2^PAGE_BITS expansion-RAM pages with its own write-protect. WIN settings go
// to shadow registers and become active together on a CTRL write with the
// commit bit set. Configuration writes are guarded by mem_map_unlock.
// Ports:
//   sys_clock_i     clock
//   reset_n_i       synchronous active-low reset
//   cpu_bus         CPU bus (be, write strobe, address, data)
//   bank_en_o       address maps to expansion RAM (combinational decode)
//   bank_page_o     selected page, 0 when not mapped
//   bank_ro_o       selected window write-protected, 0 when not mapped
//   locked_o        configuration writes are rejected (registered)
//   wp_violation_o  registered pulse: write hit a protected mapped window
// Register map from REG_BASE: +0 CTRL, +1 KEY, +2+i WIN[i].
// -----------------------------------------------------------------------------
module memory_mapper
    import memory_mapper_pkg::*;
#(
    parameter int          NUM_WINDOWS = 4,
    parameter int          PAGE_BITS   = 3,
    parameter logic [15:0] REG_BASE    = 16'hFFF0,
    parameter bit          LOCK_EN     = 1'b1
) (
    input  logic                  sys_clock_i,
    input  logic                  reset_n_i,
    memory_mapper_if.slave        cpu_bus,
    output logic                  bank_en_o,
    output logic [PAGE_BITS-1:0]  bank_page_o,
    output logic                  bank_ro_o,
    output logic                  locked_o,
    output logic                  wp_violation_o
);

    localparam int WIN_BITS  = $clog2(NUM_WINDOWS);
    localparam int WIN_IDX_W = (WIN_BITS == 0) ? 1 : WIN_BITS;

    logic                 ctrl_enable_r;
    logic                 ctrl_io_peek_r;
    logic                 ctrl_screen_peek_r;
    logic [PAGE_BITS-1:0] shadow_page_r [NUM_WINDOWS];
    logic                 shadow_wp_r   [NUM_WINDOWS];
    logic [PAGE_BITS-1:0] active_page_r [NUM_WINDOWS];
    logic                 active_wp_r   [NUM_WINDOWS];
    logic                 wp_violation_r;

    logic [3:0]           reg_off_s;
    logic                 reg_hit_s;
    logic                 reg_wr_s;
    logic                 unlocked_s;
    logic                 cfg_wr_s;
    logic [WIN_IDX_W-1:0] win_idx_s;
    logic                 peek_s;
    logic                 bank_en_s;
    logic [PAGE_BITS-1:0] bank_page_s;
    logic                 bank_ro_s;
    logic                 unused_data_s;

    // Register file occupies REG_BASE .. REG_BASE+NUM_WINDOWS+1 (16-byte aligned)
    assign reg_off_s = cpu_bus.cpu_addr[3:0];
    assign reg_hit_s = (cpu_bus.cpu_addr[15:4] == REG_BASE[15:4]) &&
                       (reg_off_s < 4'(NUM_WINDOWS + 2));
    assign reg_wr_s  = cpu_bus.cpu_be && cpu_bus.cpu_wr_strobe && reg_hit_s;
    assign cfg_wr_s  = reg_wr_s && unlocked_s;

    // Bits above the page field (other than WP) carry no state
    assign unused_data_s = ^cpu_bus.cpu_data;

    mem_map_unlock #(
        .LOCK_EN (LOCK_EN)
    ) u_unlock (
        .sys_clock_i (sys_clock_i),
        .reset_n_i   (reset_n_i),
        .reg_wr_i    (reg_wr_s),
        .is_key_i    (reg_off_s == MEM_MAP_REG_KEY),
        .data_i      (cpu_bus.cpu_data),
        .unlocked_o  (unlocked_s)
    );

    // CTRL bits, shadow WIN writes and atomic commit to the active set
    always_ff @(posedge sys_clock_i) begin
        if (!reset_n_i) begin
            ctrl_enable_r      <= 1'b0;
            ctrl_io_peek_r     <= 1'b0;
            ctrl_screen_peek_r <= 1'b0;
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                shadow_page_r[i] <= PAGE_BITS'(i);
                shadow_wp_r[i]   <= 1'b0;
                active_page_r[i] <= PAGE_BITS'(i);
                active_wp_r[i]   <= 1'b0;
            end
        end else if (cfg_wr_s) begin
            if (reg_off_s == MEM_MAP_REG_CTRL) begin
                ctrl_enable_r      <= cpu_bus.cpu_data[MEM_MAP_CTRL_ENABLE];
                ctrl_io_peek_r     <= cpu_bus.cpu_data[MEM_MAP_CTRL_IO_PEEK];
                ctrl_screen_peek_r <= cpu_bus.cpu_data[MEM_MAP_CTRL_SCREEN_PEEK];
                if (cpu_bus.cpu_data[MEM_MAP_CTRL_COMMIT]) begin
                    for (int i = 0; i < NUM_WINDOWS; i++) begin
                        active_page_r[i] <= shadow_page_r[i];
                        active_wp_r[i]   <= shadow_wp_r[i];
                    end
                end else begin
                    for (int i = 0; i < NUM_WINDOWS; i++) begin
                        active_page_r[i] <= active_page_r[i];
                        active_wp_r[i]   <= active_wp_r[i];
                    end
                end
            end else begin
                for (int i = 0; i < NUM_WINDOWS; i++) begin
                    if (reg_off_s == (MEM_MAP_REG_WIN0 + 4'(i))) begin
                        shadow_page_r[i] <= cpu_bus.cpu_data[PAGE_BITS-1:0];
                        shadow_wp_r[i]   <= cpu_bus.cpu_data[MEM_MAP_WIN_WP];
                    end else begin
                        shadow_page_r[i] <= shadow_page_r[i];
                        shadow_wp_r[i]   <= shadow_wp_r[i];
                    end
                end
            end
        end else begin
            ctrl_enable_r      <= ctrl_enable_r;
            ctrl_io_peek_r     <= ctrl_io_peek_r;
            ctrl_screen_peek_r <= ctrl_screen_peek_r;
        end
    end

    // Window index from the top address bits below A15 (0 for a single window)
    assign win_idx_s = WIN_IDX_W'(cpu_bus.cpu_addr[14:0] >> (15 - WIN_BITS));

    // Address decode from the active window set
    always_comb begin
        peek_s      = 1'b0;
        bank_en_s   = 1'b0;
        bank_page_s = '0;
        bank_ro_s   = 1'b0;
        if (ctrl_screen_peek_r && mem_map_in_screen_peek(cpu_bus.cpu_addr)) begin
            peek_s = 1'b1;
        end else if (ctrl_io_peek_r && mem_map_in_io_peek(cpu_bus.cpu_addr)) begin
            peek_s = 1'b1;
        end else begin
            peek_s = 1'b0;
        end
        if (cpu_bus.cpu_be && cpu_bus.cpu_addr[15] && ctrl_enable_r && !peek_s) begin
            bank_en_s   = 1'b1;
            bank_page_s = active_page_r[win_idx_s];
            bank_ro_s   = active_wp_r[win_idx_s];
        end else begin
            bank_en_s   = 1'b0;
            bank_page_s = '0;
            bank_ro_s   = 1'b0;
        end
    end

    // Write-protect violation pulse, one cycle after the offending strobe
    always_ff @(posedge sys_clock_i) begin
        if (!reset_n_i) begin
            wp_violation_r <= 1'b0;
        end else begin
            wp_violation_r <= cpu_bus.cpu_be && cpu_bus.cpu_wr_strobe &&
                              bank_en_s && bank_ro_s;
        end
    end

    assign bank_en_o      = bank_en_s;
    assign bank_page_o    = bank_page_s;
    assign bank_ro_o      = bank_ro_s;
    assign locked_o       = !unlocked_s;
    assign wp_violation_o = wp_violation_r;

endmodule

// File: tb/tb_memory_mapper.sv
// -----------------------------------------------------------------------------
// tb_memory_mapper
// Directed bench for memory_mapper with NUM_WINDOWS = 4, PAGE_BITS = 3,
// REG_BASE = $FFF0, LOCK_EN = 1. Registers: CTRL $FFF0, KEY $FFF1,
// WIN0..3 $FFF2..$FFF5. Windows: $8000/$A000/$C000/$E000 (8 KB each).
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
// -----------------------------------------------------------------------------
module tb_memory_mapper;

    logic       clk;
    logic       reset_n;
    logic       bank_en;
    logic [2:0] bank_page;
    logic       bank_ro;
    logic       locked;
    logic       wp_violation;

    int vectors;
    int miscompares;

    memory_mapper_if bus ();

    memory_mapper #(
        .NUM_WINDOWS (4),
        .PAGE_BITS   (3),
        .REG_BASE    (16'hFFF0),
        .LOCK_EN     (1'b1)
    ) dut (
        .sys_clock_i    (clk),
        .reset_n_i      (reset_n),
        .cpu_bus        (bus),
        .bank_en_o      (bank_en),
        .bank_page_o    (bank_page),
        .bank_ro_o      (bank_ro),
        .locked_o       (locked),
        .wp_violation_o (wp_violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle write; returns on the falling edge after the capturing edge
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_be        = 1'b1;
        bus.cpu_wr_strobe = 1'b1;
        bus.cpu_addr      = a;
        bus.cpu_data      = d;
        @(negedge clk);
        bus.cpu_be        = 1'b0;
        bus.cpu_wr_strobe = 1'b0;
    endtask

    // Present a read address and settle the combinational decode
    task automatic rd(input logic [15:0] a);
        @(negedge clk);
        bus.cpu_be        = 1'b1;
        bus.cpu_wr_strobe = 1'b0;
        bus.cpu_addr      = a;
        #1;
    endtask

    task automatic unlock();
        wr(16'hFFF1, 8'hA5);
        wr(16'hFFF1, 8'h5A);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        vectors++;
        if ({bank_en, bank_page, bank_ro} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_bank: got en=%0b page=%0d ro=%0b want 0/0/0", bank_en, bank_page, bank_ro);
        end
        vectors++;
        if (locked !== 1'b1 || wp_violation !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_lock: got locked=%0b wpv=%0b want 1/0", locked, wp_violation);
        end
        rd(16'hC000);
        vectors++;
        if (bank_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_disabled: got en=%0b want 0", bank_en);
        end
    endtask

    task automatic test_locked_write();
        wr(16'hFFF0, 8'h80);
        rd(16'hC000);
        vectors++;
        if (bank_en !== 1'b0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL locked_ctrl: got en=%0b locked=%0b want 0/1", bank_en, locked);
        end
    endtask

    task automatic test_unlock();
        wr(16'hFFF1, 8'hA5);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL key1_locked: got %0b want 1", locked);
        end
        wr(16'hFFF1, 8'h5A);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL key2_unlocked: got %0b want 0", locked);
        end
        wr(16'hFFF0, 8'h80);
        rd(16'hC000);
        vectors++;
        if (bank_en !== 1'b1 || bank_page !== 3'd2 || bank_ro !== 1'b0) begin
            miscompares++;
            $display("FAIL map_c000: got en=%0b page=%0d ro=%0b want 1/2/0", bank_en, bank_page, bank_ro);
        end
        rd(16'hA123);
        vectors++;
        if (bank_en !== 1'b1 || bank_page !== 3'd1) begin
            miscompares++;
            $display("FAIL map_a123: got en=%0b page=%0d want 1/1", bank_en, bank_page);
        end
        rd(16'h7FFF);
        vectors++;
        if (bank_en !== 1'b0 || bank_page !== 3'd0) begin
            miscompares++;
            $display("FAIL map_7fff: got en=%0b page=%0d want 0/0", bank_en, bank_page);
        end
        @(negedge clk);
        bus.cpu_be   = 1'b0;
        bus.cpu_addr = 16'hC000;
        #1;
        vectors++;
        if (bank_en !== 1'b0) begin
            miscompares++;
            $display("FAIL be_low: got en=%0b want 0", bank_en);
        end
    endtask

    task automatic test_shadow_commit();
        wr(16'hFFF5, 8'h82);
        wr(16'hFFF5, 8'h85);
        rd(16'hE000);
        vectors++;
        if (bank_page !== 3'd3 || bank_ro !== 1'b0) begin
            miscompares++;
            $display("FAIL shadow_hidden: got page=%0d ro=%0b want 3/0", bank_page, bank_ro);
        end
        wr(16'hFFF0, 8'h81);
        rd(16'hE000);
        vectors++;
        if (bank_en !== 1'b1 || bank_page !== 3'd5 || bank_ro !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_e000: got en=%0b page=%0d ro=%0b want 1/5/1", bank_en, bank_page, bank_ro);
        end
        vectors++;
        if (wp_violation !== 1'b0) begin
            miscompares++;
            $display("FAIL read_no_wpv: got %0b want 0", wp_violation);
        end
        wr(16'hE000, 8'h11);
        vectors++;
        if (wp_violation !== 1'b1) begin
            miscompares++;
            $display("FAIL wpv_pulse: got %0b want 1", wp_violation);
        end
        @(negedge clk);
        vectors++;
        if (wp_violation !== 1'b0) begin
            miscompares++;
            $display("FAIL wpv_clear: got %0b want 0", wp_violation);
        end
        wr(16'hC000, 8'h22);
        vectors++;
        if (wp_violation !== 1'b0) begin
            miscompares++;
            $display("FAIL wpv_unprotected: got %0b want 0", wp_violation);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.cpu_be        = 1'b1;
        bus.cpu_wr_strobe = 1'b1;
        bus.cpu_addr      = 16'hE100;
        bus.cpu_data      = 8'h33;
        @(negedge clk);
        vectors++;
        if (wp_violation !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: got %0b want 1", wp_violation);
        end
        @(negedge clk);
        bus.cpu_be        = 1'b0;
        bus.cpu_wr_strobe = 1'b0;
        vectors++;
        if (wp_violation !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got %0b want 1", wp_violation);
        end
        @(negedge clk);
        vectors++;
        if (wp_violation !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: got %0b want 0", wp_violation);
        end
    endtask

    task automatic test_key_abort();
        wr(16'hFFF1, 8'hA5);
        wr(16'hFFF2, 8'h07);
        wr(16'hFFF1, 8'h5A);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_locked: got %0b want 1", locked);
        end
        unlock();
        wr(16'hFFF0, 8'h81);
        rd(16'h8000);
        vectors++;
        if (bank_en !== 1'b1 || bank_page !== 3'd0 || bank_ro !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_win0: got en=%0b page=%0d ro=%0b want 1/0/0", bank_en, bank_page, bank_ro);
        end
        wr(16'hFFF1, 8'h00);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL relock: got %0b want 1", locked);
        end
        wr(16'hFFF0, 8'h00);
        rd(16'hC000);
        vectors++;
        if (bank_en !== 1'b1) begin
            miscompares++;
            $display("FAIL relock_ctrl_ignored: got en=%0b want 1", bank_en);
        end
    endtask

    task automatic test_peek();
        logic [15:0] addr_v   [8];
        logic        en_v     [8];
        logic [2:0]  page_v   [8];
        addr_v = '{16'h8100, 16'h8FFF, 16'h9000, 16'hE810, 16'hEFFF, 16'hE805, 16'hF000, 16'hE7FF};
        en_v   = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1};
        page_v = '{3'd0,     3'd0,     3'd0,     3'd0,     3'd0,     3'd5,     3'd5,     3'd5};
        unlock();
        wr(16'hFFF0, 8'hE0);
        for (int i = 0; i < 8; i++) begin
            rd(addr_v[i]);
            vectors++;
            if (bank_en !== en_v[i] || bank_page !== page_v[i] || bank_ro !== (en_v[i] && addr_v[i][14:13] == 2'd3)) begin
                miscompares++;
                $display("FAIL peek_%04h: got en=%0b page=%0d ro=%0b want en=%0b page=%0d", addr_v[i], bank_en, bank_page, bank_ro, en_v[i], page_v[i]);
            end
        end
    endtask

    task automatic test_reset_midseq();
        wr(16'hFFF3, 8'h04);
        wr(16'hFFF1, 8'hA5);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(16'hC000);
        vectors++;
        if (locked !== 1'b1 || bank_en !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset: got locked=%0b en=%0b want 1/0", locked, bank_en);
        end
        unlock();
        wr(16'hFFF0, 8'h81);
        rd(16'hA000);
        vectors++;
        if (bank_en !== 1'b1 || bank_page !== 3'd1) begin
            miscompares++;
            $display("FAIL midreset_a000: got en=%0b page=%0d want 1/1", bank_en, bank_page);
        end
        rd(16'hE000);
        vectors++;
        if (bank_page !== 3'd3 || bank_ro !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_e000: got page=%0d ro=%0b want 3/0", bank_page, bank_ro);
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset_n           = 1'b0;
        bus.cpu_be        = 1'b0;
        bus.cpu_wr_strobe = 1'b0;
        bus.cpu_addr      = 16'h0000;
        bus.cpu_data      = 8'h00;
        test_reset();
        test_locked_write();
        test_unlock();
        test_shadow_commit();
        test_back_to_back();
        test_key_abort();
        test_peek();
        test_reset_midseq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
